fp_add_arbiter: RTL and testbench

- Round-robin scheduler that shares one combinational adder_32bit instance among N_REQ operand requesters, e.g. the row accumulators of the matrix multiplier.
- Registers the granted operand pair into an issue stage that drives the adder, and captures the adder result into a response register.
- Each response is tagged with the requester ID.
- Full valid/ready flow control on both sides; one operation in flight per stage.

---
 rtl/fp_add_arbiter.sv | 141 ++++++++++++++
 tb/tb_fp_add_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin scheduler sharing one external combinational
// 32-bit adder among N_REQ operand requesters. A granted operand pair is
// registered into an ISSUE stage that drives the adder. The adder result is
// then captured, tagged with the requester ID, into a RSP stage.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req_vld/a/b             per-requester operand pairs, 32-bit slots packed LSB-first
//   o_req_rdy                 one-hot grant (combinational, gated by reset)
//   o_add_a/b, o_add_vld      ISSUE stage contents driven to the adder
//   i_add_res/_vld/_ovf       adder result, result valid and overflow flag
//   o_rsp_vld/id/res/ovf      RSP stage contents
//   i_rsp_rdy                 response consumer ready
//   o_err                     sticky flag: adder result missing while an op is issued
module fp_add_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req_vld,
  input  logic [32*N_REQ-1:0]   i_req_a,
  input  logic [32*N_REQ-1:0]   i_req_b,
  output logic [N_REQ-1:0]      o_req_rdy,
  output logic [31:0]           o_add_a,
  output logic [31:0]           o_add_b,
  output logic                  o_add_vld,
  input  logic [31:0]           i_add_res,
  input  logic                  i_add_res_vld,
  input  logic                  i_add_ovf,
  output logic                  o_rsp_vld,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [31:0]           o_rsp_res,
  output logic                  o_rsp_ovf,
  input  logic                  i_rsp_rdy,
  output logic                  o_err
);

  localparam int unsigned DW = 32;

  // Pipeline registers
  logic [DW-1:0]   r_iss_a;
  logic [DW-1:0]   r_iss_b;
  logic [ID_W-1:0] r_iss_id;
  logic            r_iss_vld;
  logic [DW-1:0]   r_rsp_res;
  logic            r_rsp_ovf;
  logic [ID_W-1:0] r_rsp_id;
  logic            r_rsp_vld;
  logic [ID_W-1:0] r_rr_ptr;
  logic            r_err;

  logic            w_rsp_free;
  logic            w_iss_free;
  logic            w_found;
  logic [ID_W-1:0] w_gnt_id;
  logic [N_REQ-1:0] w_gnt;
  logic            w_hs;
  logic [DW-1:0]   w_a_arr [N_REQ];
  logic [DW-1:0]   w_b_arr [N_REQ];

  // Modulo-N_REQ wrap for a sum of two values each below N_REQ
  function automatic int unsigned f_wrap(input int unsigned v);
    return (v >= N_REQ) ? (v - N_REQ) : v;
  endfunction

  // Unpack operand slots
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_a_arr[k] = i_req_a[DW*k +: DW];
    assign w_b_arr[k] = i_req_b[DW*k +: DW];
  end

  assign w_rsp_free = !r_rsp_vld || i_rsp_rdy;
  assign w_iss_free = !r_iss_vld || w_rsp_free;

  // Round-robin search starting at r_rr_ptr
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req_vld[ID_W'(f_wrap(32'(r_rr_ptr) + i))]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(f_wrap(32'(r_rr_ptr) + i));
      end
    end
    w_gnt = w_found ? (N_REQ'(1) << w_gnt_id) : '0;
  end

  // Grants are suppressed while the ISSUE stage cannot accept or reset is held
  assign o_req_rdy = w_gnt & {N_REQ{w_iss_free & i_rst_n}};
  assign w_hs      = w_found & w_iss_free & i_rst_n;

  // ISSUE/RSP pipeline, round-robin pointer and sticky error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iss_a   <= '0;
      r_iss_b   <= '0;
      r_iss_id  <= '0;
      r_iss_vld <= 1'b0;
      r_rsp_res <= '0;
      r_rsp_ovf <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_vld <= 1'b0;
      r_rr_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_iss_a   <= w_a_arr[w_gnt_id];
        r_iss_b   <= w_b_arr[w_gnt_id];
        r_iss_id  <= w_gnt_id;
        r_iss_vld <= 1'b1;
        r_rr_ptr  <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : (w_gnt_id + ID_W'(1));
      end else if (w_rsp_free) begin
        r_iss_vld <= 1'b0;
      end

      if (r_iss_vld && w_rsp_free) begin
        r_rsp_res <= i_add_res;
        r_rsp_ovf <= i_add_ovf;
        r_rsp_id  <= r_iss_id;
        r_rsp_vld <= 1'b1;
      end else if (i_rsp_rdy) begin
        r_rsp_vld <= 1'b0;
      end

      if (r_iss_vld && !i_add_res_vld) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_add_a   = r_iss_a;
  assign o_add_b   = r_iss_b;
  assign o_add_vld = r_iss_vld;
  assign o_rsp_vld = r_rsp_vld;
  assign o_rsp_id  = r_rsp_id;
  assign o_rsp_res = r_rsp_res;
  assign o_rsp_ovf = r_rsp_ovf;
  assign o_err     = r_err;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (ordered queue of in-flight ops
// with capacity two) and a stub adder.
module tb_fp_add_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [32*N-1:0] req_a_bus;
  logic [32*N-1:0] req_b_bus;
  logic [N-1:0]    req_rdy;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_vld;
  logic [31:0]     add_res;
  logic            add_res_vld;
  logic            add_ovf;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_res;
  logic            rsp_ovf;
  logic            rsp_rdy;
  logic            err;
  logic            inject;
  logic [32:0]     stub_out;

  always #5 clk = ~clk;

  fp_add_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(req_vld), .i_req_a(req_a_bus), .i_req_b(req_b_bus),
    .o_req_rdy(req_rdy),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_vld(add_vld),
    .i_add_res(add_res), .i_add_res_vld(add_res_vld), .i_add_ovf(add_ovf),
    .o_rsp_vld(rsp_vld), .o_rsp_id(rsp_id), .o_rsp_res(rsp_res), .o_rsp_ovf(rsp_ovf),
    .i_rsp_rdy(rsp_rdy), .o_err(err)
  );

  // Stub adder: real answers for the IEEE cases exercised, otherwise a
  // deterministic mix so routing errors show up as wrong values.
  function automatic logic [32:0] add_stub(input logic [31:0] a, input logic [31:0] b);
    logic a_sp, b_sp;
    a_sp = (a[30:23] == 8'hFF);
    b_sp = (b[30:23] == 8'hFF);
    if (a_sp || b_sp) begin
      if ((a_sp && a[22:0] != 23'd0) || (b_sp && b[22:0] != 23'd0) ||
          (a_sp && b_sp && a[31] != b[31]))
        return {1'b1, 32'h7FC00000};
      return {1'b1, (a_sp ? a[31] : b[31]), 31'h7F800000};
    end
    if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    return {a[0] & b[0], a + {b[15:0], b[31:16]}};
  endfunction

  assign stub_out    = add_stub(add_a, add_b);
  assign add_res     = stub_out[31:0];
  assign add_ovf     = stub_out[32];
  assign add_res_vld = add_vld & ~inject;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t         q[$];
  bit          shown;
  int          ptr;
  bit          merr;
  int          n_cmp;
  int          n_err;
  int          hs_cnt;
  int          rsp_cnt;
  int          gnt_log[$];
  logic [31:0] req_a[N];
  logic [31:0] req_b[N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown = 1'b0;
    ptr   = 0;
    merr  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check after settling, update model at posedge
  task automatic step(input logic [N-1:0] vld, input logic rdy);
    int          g;
    int          k;
    bit          in_iss;
    bit          rsp_free;
    bit          iss_free;
    logic [N-1:0] exp_rdy;
    logic [32:0] r;
    op_t         o;
    req_vld = vld;
    rsp_rdy = rdy;
    for (int i = 0; i < N; i++) begin
      req_a_bus[32*i +: 32] = req_a[i];
      req_b_bus[32*i +: 32] = req_b[i];
    end
    #1;
    in_iss   = shown ? (q.size() > 1) : (q.size() > 0);
    rsp_free = !shown || rdy;
    iss_free = !in_iss || rsp_free;
    g = -1;
    if (iss_free) begin
      for (int i = 0; i < N; i++) begin
        k = (ptr + i) % N;
        if (g < 0 && vld[k]) g = k;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    check_val("add_vld", 64'(add_vld), 64'(in_iss));
    if (in_iss) begin
      o = q[shown ? 1 : 0];
      check_val("add_a", 64'(add_a), 64'(o.a));
      check_val("add_b", 64'(add_b), 64'(o.b));
    end
    check_val("rsp_vld", 64'(rsp_vld), 64'(shown));
    if (shown) begin
      r = add_stub(q[0].a, q[0].b);
      check_val("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check_val("rsp_res", 64'(rsp_res), 64'(r[31:0]));
      check_val("rsp_ovf", 64'(rsp_ovf), 64'(r[32]));
    end
    check_val("err", 64'(err), 64'(merr));
    if (rsp_vld && rdy) rsp_cnt++;
    if (in_iss && inject) merr = 1'b1;
    @(posedge clk);
    if (shown && rdy) begin
      void'(q.pop_front());
      shown = 1'b0;
    end
    if (in_iss && rsp_free) shown = 1'b1;
    if (g >= 0) begin
      q.push_back('{g, req_a[g], req_b[g]});
      ptr = (g + 1) % N;
      hs_cnt++;
      gnt_log.push_back(g);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rdy"}, 64'(req_rdy), 64'd0);
    check_val({tag, "_out"}, 64'({add_vld, rsp_vld, rsp_ovf, err, rsp_id}), 64'd0);
    check_val({tag, "_data"}, {add_a, add_b}, 64'd0);
    check_val({tag, "_res"}, 64'(rsp_res), 64'd0);
  endtask

  logic [31:0] held_res;
  int          hs0;

  initial begin
    n_cmp = 0; n_err = 0; hs_cnt = 0; rsp_cnt = 0;
    inject = 1'b0;
    rst_n = 1'b0;
    req_vld = '1;
    rsp_rdy = 1'b1;
    req_a_bus = '0;
    req_b_bus = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = $urandom;
      req_b[i] = $urandom;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: all requesters valid from reset
    gnt_log.delete();
    for (int c = 0; c < 5; c++) step(4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) check_val("contend_gnt", 64'(gnt_log[c]), 64'(c % 4));
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Single op from requester 2
    req_a[2] = 32'h3F800000;
    req_b[2] = 32'h40000000;
    gnt_log.delete();
    step(4'b0100, 1'b1);
    check_val("single_gnt", 64'(gnt_log.size() == 1 ? gnt_log[0] : -1), 64'd2);
    step(4'b0000, 1'b1);
    #1;
    check_val("single_vld", 64'(rsp_vld), 64'd1);
    check_val("single_id", 64'(rsp_id), 64'd2);
    check_val("single_res", 64'(rsp_res), 64'h40400000);
    check_val("single_ovf", 64'(rsp_ovf), 64'd0);

    // Special values: +Inf + -Inf
    req_a[0] = 32'h7F800000;
    req_b[0] = 32'hFF800000;
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    #1;
    check_val("special_res", 64'(rsp_res), 64'h7FC00000);
    check_val("special_ovf", 64'(rsp_ovf), 64'd1);
    step(4'b0000, 1'b1);

    // Backpressure: streaming requester 1 with consumer stalled
    hs0 = hs_cnt;
    req_a[1] = $urandom;
    req_b[1] = $urandom;
    step(4'b0010, 1'b0);
    req_a[1] = $urandom;
    step(4'b0010, 1'b0);
    #1;
    held_res = rsp_res;
    for (int c = 0; c < 3; c++) begin
      req_a[1] = $urandom;
      step(4'b0010, 1'b0);
      check_val("bp_stable", 64'(rsp_res), 64'(held_res));
    end
    check_val("bp_handshakes", 64'(hs_cnt - hs0), 64'd2);
    rsp_cnt = 0;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
    check_val("bp_drained", 64'(rsp_cnt), 64'd2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i] = ($urandom_range(0, 15) == 0) ? 32'h7F800000 : 32'($urandom);
        req_b[i] = ($urandom_range(0, 15) == 0) ? 32'hFF800000 : 32'($urandom);
      end
      step(4'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);

    // Protocol error: withhold the adder result valid for one issued cycle
    step(4'b0001, 1'b1);
    inject = 1'b1;
    step(4'b0000, 1'b1);
    inject = 1'b0;
    for (int c = 0; c < 3; c++) step(4'($urandom), 1'b1);
    #1;
    check_val("err_sticky", 64'(err), 64'd1);

    // Reset mid-flight with both stages occupied
    for (int c = 0; c < 3; c++) step(4'b1111, 1'b0);
    #1;
    check_val("prefill", 64'({add_vld, rsp_vld}), 64'h3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    step(4'b1111, 1'b1);
    check_val("post_reset_gnt", 64'(gnt_log.size() == 1 ? gnt_log[0] : -1), 64'd0);
    for (int c = 0; c < 6; c++) step(4'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
